mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (read-only) and data port (read/write). It sits between the IF/MEM stages and the memory macro. It grants at most one access per cycle and tracks in-flight reads so each return is routed to its owner. Data accesses win by default, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_W, 10, word-address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles from issue to mem_rdata valid (≥1)
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced through (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch read request; held with i_addr stable until granted
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  d_rdata valid (reads only)
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read issue

## Operation
- Grant decision is combinational from the requests and registered state. Memory outputs are driven in the grant cycle.
- Priority: d_req wins unless starve_cnt == STARVE_MAX and i_req = 1; then i wins.
- starve_cnt: +1 on each cycle where d is granted while i_req = 1, saturating at STARVE_MAX. Cleared to 0 on any i grant, or on any cycle with i_req = 0.
- Granted writes: mem_en = 1, mem_we = 1, with d_wdata. The write completes on that edge. No rvalid is produced.
- Granted reads: mem_en = 1, mem_we = 0. An owner tag (I or D) is pushed into a MEM_LAT-deep tag shift register.
- Return path: when the tag exiting the shift register is I, i_rvalid = 1 and i_rdata = mem_rdata. When it is D, d_rvalid = 1 and d_rdata = mem_rdata. Otherwise both rvalids are 0.
- Reads may issue every cycle, giving full throughput with MEM_LAT reads in flight.
- When idle: mem_en = 0; mem_addr, mem_wdata and mem_we = 0.
- rdata outputs are don't-care when the matching rvalid is 0. The bench checks rdata only under rvalid.

## Timing
- Reset (rst = 0, asynchronous): tag register cleared to NONE and starve_cnt = 0. Therefore i_rvalid = 0 and d_rvalid = 0 from reset assertion onward. Grants and mem_en are 0 while rst = 0.
- Reset mid-operation drops in-flight reads: no rvalid is ever produced for a read issued before reset.
- Grant latency: same cycle when uncontended. A losing requester waits, with no limit on d. For i, the wait is ≤ STARVE_MAX + 1 cycles under continuous d_req.
- Read latency: rvalid is asserted exactly MEM_LAT cycles after the gnt cycle.
- A write followed by a read of the same address in the next cycle returns the new data (memory ordering).
- Simultaneous i and d returns cannot occur, because only one issue happens per cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - owner enum {OWN_NONE, OWN_I, OWN_D};
  - default MEM_LAT and STARVE_MAX constants.
- Sub-module mem_arb_tagpipe: a parameterised MEM_LAT-stage owner-tag shift register with asynchronous active-low clear. It outputs the exiting tag.
- The top level contains the priority logic, the starvation counter and the output muxing.

## Test plan
- Reset: hold rst = 0 for 3 cycles with both reqs high → all gnt/rvalid/mem_en = 0. Release, then i_req only at addr 0x010 → i_gnt in the same cycle; i_rvalid with mem[0x010] 2 cycles later.
- Contention: i_req and d_req (read 0x020) together for 1 cycle → d_gnt first, i_gnt next cycle. Returns are d_rvalid at t+2 and i_rvalid at t+3, each with the correct data.
- Starvation: d_req read continuously with i_req high → exactly 4 d grants, then 1 i grant, then d resumes. starve_cnt returns to 0.
- Write/read ordering: d write 0xDEADBEEF to 0x005, then d read 0x005 on the next cycle → d_rvalid 2 cycles later with 0xDEADBEEF. No rvalid occurs for the write.
- Back-to-back pipelining: alternate i/d reads every cycle for 8 cycles → 8 rvalids in issue order, each on the correct port, with no bubbles.
- Reset mid-flight: issue two reads, then pulse rst low at t+1 → no rvalid appears on either port afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: read-owner tags and
// default latency / starvation limits.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_tagpipe.sv
// Owner-tag delay line: a tag entering on an issue cycle leaves exactly
// MEM_LAT cycles later, lined up with the matching memory read data.
module mem_arb_tagpipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_e tag_in,
    output owner_e tag_out
);

    owner_e stage_q [MEM_LAT];
    owner_e stage_d [MEM_LAT];

    // Next stage contents: new tag at the head, everything else moves one step
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < MEM_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; clearing drops every in-flight read on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch
// (read-only) and the data port. Data wins by default; a starvation counter
// forces a fetch through after STARVE_MAX back-to-back data wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             force_i;
    logic             grant_i;
    logic             grant_d;
    owner_e           tag_in;
    owner_e           tag_out;

    // Priority: data first unless fetch has waited out its starvation budget;
    // nothing is granted while reset is held
    always_comb begin
        force_i = i_req && (starve_cnt_q == CNT_MAX);
        grant_d = rst && d_req && !force_i;
        grant_i = rst && i_req && !grant_d;
    end

    // Starvation count: grows on data wins over a waiting fetch, saturates,
    // and clears as soon as fetch is served or stops asking
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || grant_i) begin
            starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Memory strobes in the grant cycle; idle cycles drive all zeros
    always_comb begin
        mem_en    = grant_i || grant_d;
        mem_we    = grant_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_in    = OWN_NONE;
        if (grant_i) begin
            mem_addr = i_addr;
            tag_in   = OWN_I;
        end else if (grant_d) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_wdata = d_wdata;
            end else begin
                tag_in = OWN_D;
            end
        end
    end

    mem_arb_tagpipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tagpipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Return routing: the tag leaving the pipe says whose read data this is
    always_comb begin
        i_rvalid = (tag_out == OWN_I);
        d_rvalid = (tag_out == OWN_D);
        i_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory macro, queued requesters that
// hold requests until granted, a per-cycle arbitration reference model and a
// scoreboard monitor that matches every read return to its expected owner,
// data and arrival cycle.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic              is_d;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dreq_t;

    int                checks;
    int                errors;
    int                cyc;
    int                starve;
    logic [DATA_W-1:0] salt;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    bit                mem_init_done;
    exp_t              exp_q [$];
    logic [ADDR_W-1:0] i_q   [$];
    dreq_t             d_q   [$];
    logic              drv_gi;
    logic              drv_gd;

    function automatic logic [DATA_W-1:0] initVal(input int a, input logic [DATA_W-1:0] s);
        return (DATA_W'(a) * 32'h9E37_79B1) ^ s;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro: writes land on the edge, reads return MEM_LAT cycles later
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= initVal(a, salt);
            mem_init_done <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : '0;
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Requesters: present queued requests and hold each one until granted
    initial begin
        forever begin
            @(negedge clk);
            drv_gi = i_gnt;
            drv_gd = d_gnt;
            @(posedge clk);
            #1;
            if (drv_gi) i_req = 1'b0;
            if (drv_gd) d_req = 1'b0;
            if (!i_req && i_q.size() > 0) begin
                i_addr = i_q.pop_front();
                i_req  = 1'b1;
            end
            if (!d_req && d_q.size() > 0) begin
                dreq_t r;
                r       = d_q.pop_front();
                d_we    = r.we;
                d_addr  = r.addr;
                d_wdata = r.wdata;
                d_req   = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input bit do_i, input logic [ADDR_W-1:0] ia,
                                 input bit do_d, input logic we,
                                 input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd);
        dreq_t r;
        if (do_i) i_q.push_back(ia);
        if (do_d) begin
            r.we    = we;
            r.addr  = da;
            r.wdata = wd;
            d_q.push_back(r);
        end
    endtask

    // Reference model: who should win this cycle, what the memory should see,
    // and which read data must come back when
    task automatic checkOutput();
        logic              ei, ed, ewe;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ewd;
        exp_t              e;
        ei = 1'b0;
        ed = 1'b0;
        if (rst) begin
            if (i_req && starve == STARVE_MAX) ei = 1'b1;
            else if (d_req)                    ed = 1'b1;
            else if (i_req)                    ei = 1'b1;
        end
        ewe = ed && d_we;
        ea  = ei ? i_addr : (ed ? d_addr : '0);
        ewd = ewe ? d_wdata : '0;
        checks++;
        if ({i_gnt, d_gnt, mem_en, mem_we, mem_addr} !== {ei, ed, ei | ed, ewe, ea}) begin
            errors++;
            $display("[TB] FAIL grant cyc=%0d got gi=%b gd=%b en=%b we=%b addr=%h, expected gi=%b gd=%b en=%b we=%b addr=%h",
                     cyc, i_gnt, d_gnt, mem_en, mem_we, mem_addr, ei, ed, ei | ed, ewe, ea);
        end
        if (ewe || !(ei || ed)) begin
            checks++;
            if (mem_wdata !== ewd) begin
                errors++;
                $display("[TB] FAIL wdata cyc=%0d got %h expected %h", cyc, mem_wdata, ewd);
            end
        end
        if (ei) begin
            e.is_d = 1'b0; e.data = ref_mem[i_addr]; e.due = cyc + MEM_LAT;
            exp_q.push_back(e);
        end else if (ed && !d_we) begin
            e.is_d = 1'b1; e.data = ref_mem[d_addr]; e.due = cyc + MEM_LAT;
            exp_q.push_back(e);
        end else if (ewe) begin
            ref_mem[d_addr] = d_wdata;
        end
        if (!rst || !i_req || ei) starve = 0;
        else if (ed && starve < STARVE_MAX) starve++;
    endtask

    always @(negedge clk) checkOutput();

    // Scoreboard monitor: every return must match the oldest outstanding read
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            checks++;
            if (i_rvalid || d_rvalid) begin
                errors++;
                $display("[TB] FAIL reset_rvalid cyc=%0d got i=%b d=%b expected 0 0", cyc, i_rvalid, d_rvalid);
            end
            exp_q.delete();
        end else if (i_rvalid && d_rvalid) begin
            checks++;
            errors++;
            $display("[TB] FAIL dual_rvalid cyc=%0d both rvalids high, expected at most one", cyc);
        end else if (i_rvalid || d_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rvalid cyc=%0d got i=%b d=%b with no read outstanding", cyc, i_rvalid, d_rvalid);
            end else begin
                e = exp_q.pop_front();
                if (d_rvalid !== e.is_d || cyc != e.due
                    || (d_rvalid ? d_rdata : i_rdata) !== e.data) begin
                    errors++;
                    $display("[TB] FAIL return cyc=%0d got port_d=%b data=%h, expected port_d=%b data=%h at cyc=%0d",
                             cyc, d_rvalid, d_rvalid ? d_rdata : i_rdata, e.is_d, e.data, e.due);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("[TB] FAIL missing_rvalid cyc=%0d no return, expected port_d=%b data=%h", cyc, e.is_d, e.data);
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((i_q.size() > 0 || d_q.size() > 0 || i_req || d_req) && n < 100);
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout cyc=%0d requests still pending after %0d cycles, expected drained", cyc, n);
        end
    endtask

    initial begin
        int n;
        rst     = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        starve  = 0;
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        salt    = $urandom;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = initVal(a, salt);

        // Both requests raised while reset is held: nothing may be granted
        applyStimulus(1'b1, 10'h003, 1'b1, 1'b0, 10'h004, '0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        waitIdle();
        repeat (MEM_LAT + 1) @(negedge clk);

        // Uncontended fetch
        $display("[TB] fetch only");
        applyStimulus(1'b1, 10'h010, 1'b0, 1'b0, '0, '0);
        waitIdle();
        repeat (MEM_LAT + 1) @(negedge clk);

        // Contention: data first, fetch the cycle after
        $display("[TB] contention");
        applyStimulus(1'b1, 10'h030, 1'b1, 1'b0, 10'h020, '0);
        waitIdle();
        repeat (MEM_LAT + 1) @(negedge clk);

        // Starvation: continuous data reads with fetch waiting
        $display("[TB] starvation");
        for (int k = 0; k < 7; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0, ADDR_W'(10'h100 + k), '0);
        applyStimulus(1'b1, 10'h050, 1'b0, 1'b0, '0, '0);
        waitIdle();
        repeat (MEM_LAT + 1) @(negedge clk);

        // Write then read the same word on the next cycle
        $display("[TB] write/read ordering");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 10'h005, '0);
        waitIdle();
        repeat (MEM_LAT + 1) @(negedge clk);

        // Alternating fetch/data reads every cycle
        $display("[TB] back-to-back");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, ADDR_W'(10'h200 + k), 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, ADDR_W'(10'h300 + k), '0);
            @(negedge clk);
        end
        waitIdle();
        repeat (MEM_LAT + 1) @(negedge clk);

        // Reset while two reads are in flight: neither may ever return
        $display("[TB] reset mid-flight");
        applyStimulus(1'b1, 10'h040, 1'b1, 1'b0, 10'h041, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_gnt && n < 20);
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL fetch_grant_timeout cyc=%0d got no i_gnt, expected one", cyc);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (MEM_LAT + 4) @(negedge clk);

        // Randomised traffic with occasional reset pulses
        $display("[TB] random traffic");
        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 35 && i_q.size() == 0)
                applyStimulus(1'b1, ADDR_W'($urandom_range(0, 15)), 1'b0, 1'b0, '0, '0);
            if ($urandom_range(0, 99) < 60 && d_q.size() < 2)
                applyStimulus(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)),
                              ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #1 rst = 1'b1;
            end
        end
        waitIdle();
        repeat (MEM_LAT + 3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
